// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the core (c_*), auxiliary (a_*) and memory (mem_*)
// signals of the data-memory arbiter.
//
// Handshake: a requester raises *_req with its command fields and holds them
// stable until the cycle in which *_gnt is 1; that cycle is the transfer and
// the request may change or drop afterwards. *_gnt is combinational in the
// same cycle as *_req. Read data comes back exactly one cycle after the grant
// as a single-cycle *_rvalid pulse with *_rdata; there is no back-pressure on
// read data. mem_en is the memory strobe, and mem_rdata is valid one cycle
// after a read strobe.
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [3:0]    c_be;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [3:0]    a_be;
    logic          a_lock;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_be,
        output c_gnt, c_rvalid, c_rdata,
        input  a_req, a_we, a_addr, a_wdata, a_be, a_lock,
        output a_gnt, a_rvalid, a_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    // Environment side: requesters and the memory.
    modport master (
        output c_req, c_we, c_addr, c_wdata, c_be,
        input  c_gnt, c_rvalid, c_rdata,
        output a_req, a_we, a_addr, a_wdata, a_be, a_lock,
        input  a_gnt, a_rvalid, a_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of the single-port data memory.
// The core (C) has fixed priority. The auxiliary port (A) is protected from
// starvation and can lock the memory for uninterrupted bursts. Read data is
// routed back to the requester that issued the read, one cycle after the grant.
//
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN. When it is defined, priority
// in IDLE alternates between the requesters and the starvation counter is
// removed. LOCK behaves the same in both builds.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = LOCK.
module dmem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            rst,
    dmem_arbiter_if.slave   bus,
    output logic            dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          c_gnt_w, a_gnt_w;
    logic          rd_pend;
    logic          rd_own;          // 1 = read belongs to A
    logic [DW-1:0] c_rdata_q, a_rdata_q;
    logic          c_rvalid_w, a_rvalid_w;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic          last_gnt;        // 1 = A was granted last
    logic          a_first;
    assign a_first = (last_gnt == 1'b0);
`else
    logic [7:0]    starve_cnt;
    logic          starved;
    assign starved = (starve_cnt == 8'(STARVE_LIMIT));
`endif

    // Grant selection and next state; no grant is issued during reset.
    always_comb begin
        state_d = state_q;
        c_gnt_w = 1'b0;
        a_gnt_w = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    if (bus.c_req && bus.a_req) begin
                        a_gnt_w = a_first;
                        c_gnt_w = !a_first;
                    end else begin
                        c_gnt_w = bus.c_req;
                        a_gnt_w = bus.a_req;
                    end
`else
                    if (bus.a_req && starved) begin
                        a_gnt_w = 1'b1;
                    end else if (bus.c_req) begin
                        c_gnt_w = 1'b1;
                    end else begin
                        a_gnt_w = bus.a_req;
                    end
`endif
                    if (a_gnt_w && bus.a_lock) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    // A keeps ownership even while idle; the cycle a_lock
                    // drops still belongs to A.
                    a_gnt_w = bus.a_req;
                    if (!bus.a_lock) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Remember who was granted last so the other one wins the next conflict.
    always_ff @(posedge clock) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (c_gnt_w) begin
            last_gnt <= 1'b0;
        end else if (a_gnt_w) begin
            last_gnt <= 1'b1;
        end
    end
`else
    // Count consecutive refused A cycles in IDLE, saturating at the limit.
    always_ff @(posedge clock) begin
        if (rst || !bus.a_req || a_gnt_w) begin
            starve_cnt <= 8'd0;
        end else if (state_q == IDLE && !starved) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`endif

    assign bus.c_gnt     = c_gnt_w;
    assign bus.a_gnt     = a_gnt_w;
    assign bus.mem_en    = c_gnt_w | a_gnt_w;
    assign bus.mem_we    = a_gnt_w ? bus.a_we    : bus.c_we;
    assign bus.mem_addr  = a_gnt_w ? bus.a_addr  : bus.c_addr;
    assign bus.mem_wdata = a_gnt_w ? bus.a_wdata : bus.c_wdata;
    assign bus.mem_be    = a_gnt_w ? bus.a_be    : bus.c_be;

    // Track the read issued this cycle and who owns its return data.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_own  <= 1'b0;
        end else begin
            rd_pend <= (c_gnt_w | a_gnt_w) & ~bus.mem_we;
            rd_own  <= a_gnt_w;
        end
    end

    // A pending read is dropped if reset arrives in its return cycle.
    assign c_rvalid_w = rd_pend & ~rd_own & ~rst;
    assign a_rvalid_w = rd_pend &  rd_own & ~rst;

    // Hold the last returned word for each requester between reads.
    always_ff @(posedge clock) begin
        if (rst) begin
            c_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            if (c_rvalid_w) begin
                c_rdata_q <= bus.mem_rdata;
            end
            if (a_rvalid_w) begin
                a_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.c_rvalid = c_rvalid_w;
    assign bus.a_rvalid = a_rvalid_w;
    assign bus.c_rdata  = rst ? '0 : (c_rvalid_w ? bus.mem_rdata : c_rdata_q);
    assign bus.a_rdata  = rst ? '0 : (a_rvalid_w ? bus.mem_rdata : a_rdata_q);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus for dmem_arbiter, checked each
// cycle against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- memory device ----------------
  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 32'h0001_2B11;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end else begin
          bus.mem_rdata <= mem[bus.mem_addr];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   exp_q[$];        // {owner_is_a, data} of reads due next cycle
  logic          m_locked = 1'b0;
  int            m_refused = 0;
  logic          m_last_a = 1'b1;
  logic [DW-1:0] m_c_rdata = '0;
  logic [DW-1:0] m_a_rdata = '0;
  logic          last_ega = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic void model_grant(output logic egc, output logic ega);
    egc = 1'b0;
    ega = 1'b0;
    if (rst) return;
    if (m_locked) begin
      ega = bus.a_req;
      return;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (bus.c_req && bus.a_req) begin
      egc = m_last_a;
      ega = !m_last_a;
    end else begin
      egc = bus.c_req;
      ega = bus.a_req;
    end
`else
    if (bus.a_req && m_refused >= STARVE_LIMIT) ega = 1'b1;
    else if (bus.c_req) egc = 1'b1;
    else ega = bus.a_req;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic egc, ega, exp_crv, exp_arv;
    logic [DW:0] ent;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0] s_be;
    logic s_we;
    @(negedge clock);
    model_grant(egc, ega);
    exp_crv = 1'b0;
    exp_arv = 1'b0;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      if (!rst) begin
        if (ent[DW]) begin exp_arv = 1'b1; m_a_rdata = ent[DW-1:0]; end
        else         begin exp_crv = 1'b1; m_c_rdata = ent[DW-1:0]; end
      end
    end
    s_we    = ega ? bus.a_we    : bus.c_we;
    s_addr  = ega ? bus.a_addr  : bus.c_addr;
    s_wdata = ega ? bus.a_wdata : bus.c_wdata;
    s_be    = ega ? bus.a_be    : bus.c_be;
    check("c_gnt", DW'(bus.c_gnt), DW'(egc));
    check("a_gnt", DW'(bus.a_gnt), DW'(ega));
    check("mem_en", DW'(bus.mem_en), DW'(egc | ega));
    if (egc | ega) begin
      check("mem_we", DW'(bus.mem_we), DW'(s_we));
      check("mem_addr", DW'(bus.mem_addr), DW'(s_addr));
      check("mem_be", DW'(bus.mem_be), DW'(s_be));
      if (s_we) check("mem_wdata", bus.mem_wdata, s_wdata);
    end
    check("c_rvalid", DW'(bus.c_rvalid), DW'(exp_crv));
    check("a_rvalid", DW'(bus.a_rvalid), DW'(exp_arv));
    check("c_rdata", bus.c_rdata, rst ? '0 : m_c_rdata);
    check("a_rdata", bus.a_rdata, rst ? '0 : m_a_rdata);
    check("state", DW'(dbg_state), DW'(m_locked));
    @(posedge clock);
    if (rst) begin
      m_locked = 1'b0;
      m_refused = 0;
      m_last_a = 1'b1;
      m_c_rdata = '0;
      m_a_rdata = '0;
      exp_q.delete();
    end else begin
      if (egc | ega) begin
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_be[b]) ref_mem[s_addr][8*b +: 8] = s_wdata[8*b +: 8];
        end else begin
          exp_q.push_back({ega, ref_mem[s_addr]});
        end
      end
      if (!bus.a_req || ega) m_refused = 0;
      else if (!m_locked && m_refused < STARVE_LIMIT) m_refused++;
      if (egc) m_last_a = 1'b0;
      if (ega) m_last_a = 1'b1;
      if (m_locked) m_locked = bus.a_lock;
      else if (ega && bus.a_lock) m_locked = 1'b1;
    end
    last_ega = ega;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_c(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [3:0] be);
    bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd; bus.c_be = be;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [3:0] be, input logic lock);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_be = be;
    bus.a_lock = lock;
  endtask

  // Tick until the model grants A, within a bounded number of cycles.
  task automatic wait_a_grant();
    int budget = 2 * STARVE_LIMIT + 4;
    do begin
      tick();
      budget--;
    end while (!last_ega && budget > 0);
    if (!last_ega) begin
      n_cmp++;
      n_err++;
      $error("FAIL a_grant_wait: observed no grant expected grant within budget");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    set_c(0, 0, '0, '0, 4'h0);
    set_a(0, 0, '0, '0, 4'h0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // C read of word 5, then A write of word 7.
    set_c(1, 0, 10'd5, '0, 4'hF);
    tick();
    set_c(0, 0, '0, '0, 4'h0);
    set_a(1, 1, 10'd7, 32'hDEAD_BEEF, 4'hF, 0);
    tick();
    set_a(0, 0, '0, '0, 4'h0, 0);
    tick();
    tick();

    // Continuous conflict: starvation override every 5th cycle.
    for (int i = 0; i < 15; i++) begin
      set_c(1, 0, 10'($urandom_range(0, DEPTH - 1)), '0, 4'hF);
      set_a(1, 0, 10'($urandom_range(0, DEPTH - 1)), '0, 4'hF, 0);
      tick();
    end
    set_c(0, 0, '0, '0, 4'h0);
    set_a(0, 0, '0, '0, 4'h0, 0);
    tick();

    // Locked burst of three A reads with gaps while C keeps requesting.
    set_c(1, 0, 10'd9, '0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      set_a(1, 0, 10'(k), '0, 4'hF, 1);
      wait_a_grant();
      set_a(0, 0, '0, '0, 4'h0, 1);
      tick();
    end
    set_a(0, 0, '0, '0, 4'h0, 0);
    tick();
    tick();
    set_c(0, 0, '0, '0, 4'h0);
    tick();

    // Reset in the return cycle of an A read.
    set_a(1, 0, 10'd3, '0, 4'hF, 0);
    tick();
    set_a(0, 0, '0, '0, 4'h0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Back-to-back reads from different requesters.
    set_c(1, 0, 10'd1, '0, 4'hF);
    tick();
    set_c(0, 0, '0, '0, 4'h0);
    set_a(1, 0, 10'd2, '0, 4'hF, 0);
    tick();
    set_a(0, 0, '0, '0, 4'h0, 0);
    tick();
    tick();

    // Random traffic with occasional locks, partial writes and resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_c($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      set_a($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0;
    set_c(0, 0, '0, '0, 4'h0);
    set_a(0, 0, '0, '0, 4'h0, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester C is the core load/store path. Requester A is an auxiliary master: a debug or loader port that preloads or inspects dMem while the core runs.
- Issues at most one memory access per cycle and routes synchronous-read data back to the requester that issued the read.
- Fixed priority to C, starvation protection for A, and an A-side lock for uninterrupted bursts.

Parameters:
- AW, 10, word-address width of memory and both requesters.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles A may be refused before it gets forced priority (1..255).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clock.
- c_req  input  1  core access request; held until c_gnt.
- c_we  input  1  core write enable (1 = store).
- c_addr  input  AW  core word address.
- c_wdata  input  DW  core store data.
- c_be  input  4  core byte enables.
- c_gnt  output  1  core request accepted this cycle (combinational).
- c_rvalid  output  1  core read data valid (registered).
- c_rdata  output  DW  core read data.
- a_req, a_we, a_addr, a_wdata, a_be  input  1/1/AW/DW/4  auxiliary request; same meaning as the C signals.
- a_lock  input  1  A holds ownership after its next grant until deasserted.
- a_gnt  output  1  aux request accepted this cycle (combinational).
- a_rvalid  output  1  aux read data valid (registered).
- a_rdata  output  DW  aux read data.
- mem_en, mem_we  output  1/1  memory access strobe and write enable.
- mem_addr, mem_wdata, mem_be  output  AW/DW/4  forwarded from the granted requester.
- mem_rdata  input  DW  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - state=IDLE; starve_cnt=0; rd_pend=0.
  - c_rvalid, a_rvalid, c_rdata and a_rdata are all 0.
  - gnt and mem_en are 0 in the cycle rst is high.
- Grant rules per cycle (same cycle as request, combinational):
  - At most one of c_gnt/a_gnt is 1, and mem_en = c_gnt|a_gnt.
  - The mem_* mux selects the granted requester; mem_* are don't-care when mem_en=0 but are driven from C.
- States:
  - IDLE (C priority): C requesting -> grant C. Otherwise A requesting -> grant A.
  - Starvation in IDLE: if starve_cnt==STARVE_LIMIT and A requesting, grant A even if C requests.
  - IDLE -> LOCK: when A is granted with a_lock=1, next state is LOCK.
  - LOCK: only A may be granted; c_gnt=0. A may idle (a_req=0) inside LOCK without losing ownership.
  - LOCK -> IDLE: the first cycle a_lock=0 (a grant in that cycle is still A's).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle a_req=1 and a_gnt=0.
  - Clears on a_gnt, and clears whenever a_req=0.
  - Not incremented while in LOCK.
- Read return:
  - A granted read sets rd_pend=1 and rd_own=granted id.
  - Next cycle: the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rdata holds its previous value.
  - Back-to-back reads are allowed every cycle; rd_pend tracks each cycle independently. Latency is exactly 1 cycle.
- Writes: no rvalid is generated.
- rst mid-operation: a pending read is discarded (no rvalid) and LOCK is left immediately.
- Simultaneous c_req and a_req in IDLE with starve_cnt<STARVE_LIMIT: C wins and A's counter increments.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: IDLE priority alternates. A 1-bit last_gnt register (reset to A, so C wins the first conflict) gives priority to the requester not granted last. starve_cnt logic and the STARVE_LIMIT override are removed; LOCK is unchanged.
- Undefined: fixed C priority with starvation override as above.

Test Plan:
- C read then A write:
  - Stimulus: mem word 5 = 0x0001_2B11; C reads addr 5 at cycle t; A writes 0xDEAD_BEEF to addr 7 at t+1.
  - Required: c_gnt at t; c_rvalid and c_rdata=0x0001_2B11 at t+1; a_gnt at t+1; a_rvalid never asserts.
- Conflict:
  - Stimulus: C and A both request continuously with STARVE_LIMIT=4.
  - Required: C granted 4 cycles, A granted on the 5th, then C again. The pattern repeats with period 5.
- Lock burst:
  - Stimulus: A asserts a_lock and does 3 reads of addrs 0..2 with a 1-cycle a_req gap, while C requests throughout.
  - Required: c_gnt=0 until a_lock drops; a_rvalid pulses carry words 0..2; C is granted in the cycle after a_lock falls.
- Reset mid-read:
  - Stimulus: rst asserted in the cycle after an A read grant.
  - Required: no a_rvalid; all outputs 0; state IDLE.
- Round robin (macro defined):
  - Stimulus: both requesting continuously.
  - Required: grants alternate C,A,C,A starting with C after reset.
- Back-to-back reads:
  - Stimulus: C reads addr 1 then A reads addr 2 on consecutive cycles.
  - Required: c_rvalid then a_rvalid on consecutive cycles, with correct data each.
